// File: rtl/rx_frame_buffer_ctrl.sv
// Store-and-forward receive buffer: captures an unstallable byte stream into a circular
// byte RAM, commits only complete frames, and replays them over AXI-Stream with backpressure.
module rx_frame_buffer_ctrl #(
  parameter int DEPTH_BYTES = 2048,
  parameter int MAX_FRAMES  = 8,
  parameter int CNT_W       = 16
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          s_axis_tvalid_i,
  input  logic [7:0]                    s_axis_tdata_i,
  input  logic                          s_axis_tlast_i,
  output logic                          m_axis_tvalid_o,
  output logic [7:0]                    m_axis_tdata_o,
  output logic                          m_axis_tlast_o,
  input  logic                          m_axis_tready_i,
  output logic [$clog2(MAX_FRAMES):0]   frames_pending_o,
  output logic [CNT_W-1:0]              drop_count_o
);

  localparam int AW = $clog2(DEPTH_BYTES);
  localparam int PW = AW + 1;
  localparam int QA = $clog2(MAX_FRAMES);
  localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH_BYTES);
  localparam logic [QA:0]   MAXF_P  = (QA + 1)'(MAX_FRAMES);

  typedef enum logic [1:0] {W_IDLE, W_RX, W_DROP} w_state_e;
  typedef enum logic [1:0] {R_IDLE, R_LOAD, R_SEND} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     commit_ptr_q, commit_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     len_q, len_d;
  logic [PW-1:0]     remaining_q, remaining_d;
  logic [QA:0]       q_wr_q, q_wr_d;
  logic [QA:0]       q_rd_q, q_rd_d;
  logic [QA:0]       pending_q, pending_d;
  logic [CNT_W-1:0]  drop_q, drop_d;
  logic              m_valid_q, m_valid_d;
  logic              m_last_q, m_last_d;
  logic [7:0]        m_data_q, m_data_d;

  logic [7:0]        mem [DEPTH_BYTES];
  logic [PW-1:0]     lenq [MAX_FRAMES];
  logic [7:0]        rdata_q;
  logic [AW-1:0]     rd_addr;
  logic              we, eof, push, complete, drop_inc;
  logic              buf_full, q_full;

  assign buf_full = (wr_ptr_q - rd_ptr_q) == DEPTH_P;
  // A frame being replayed still occupies a slot until its last byte leaves.
  assign q_full   = pending_q == MAXF_P;

  // Write side: never stalls, rolls back to commit_ptr on any drop.
  always_comb begin
    w_state_d    = w_state_q;
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    len_d        = len_q;
    we           = 1'b0;
    eof          = 1'b0;
    push         = 1'b0;
    drop_inc     = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axis_tvalid_i) begin
          if (buf_full) begin
            if (s_axis_tlast_i) drop_inc = 1'b1;
            else                w_state_d = W_DROP;
          end else begin
            we        = 1'b1;
            wr_ptr_d  = wr_ptr_q + PW'(1);
            len_d     = PW'(1);
            eof       = s_axis_tlast_i;
            w_state_d = W_RX;
          end
        end
      end
      W_RX: begin
        if (s_axis_tvalid_i && buf_full) begin
          wr_ptr_d = commit_ptr_q;
          if (s_axis_tlast_i) begin
            drop_inc  = 1'b1;
            w_state_d = W_IDLE;
          end else begin
            w_state_d = W_DROP;
          end
        end else begin
          if (s_axis_tvalid_i) begin
            we       = 1'b1;
            wr_ptr_d = wr_ptr_q + PW'(1);
            len_d    = len_q + PW'(1);
          end
          eof = s_axis_tlast_i;
        end
      end
      W_DROP: begin
        if (s_axis_tlast_i) begin
          drop_inc  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    if (eof) begin
      w_state_d = W_IDLE;
      if (q_full) begin
        wr_ptr_d = commit_ptr_q;
        drop_inc = 1'b1;
      end else begin
        push         = 1'b1;
        commit_ptr_d = wr_ptr_d;
      end
    end
  end

  // Read side: rdata_q tracks mem[rd_ptr+1] while sending so beats can run back-to-back.
  always_comb begin
    r_state_d   = r_state_q;
    rd_ptr_d    = rd_ptr_q;
    remaining_d = remaining_q;
    q_rd_d      = q_rd_q;
    m_valid_d   = m_valid_q;
    m_data_d    = m_data_q;
    m_last_d    = m_last_q;
    complete    = 1'b0;
    rd_addr     = rd_ptr_q[AW-1:0];
    case (r_state_q)
      R_IDLE: begin
        if (q_wr_q != q_rd_q) begin
          remaining_d = lenq[q_rd_q[QA-1:0]];
          q_rd_d      = q_rd_q + (QA + 1)'(1);
          r_state_d   = R_LOAD;
        end
      end
      R_LOAD: begin
        m_valid_d = 1'b1;
        m_data_d  = rdata_q;
        m_last_d  = remaining_q == PW'(1);
        rd_addr   = rd_ptr_q[AW-1:0] + AW'(1);
        r_state_d = R_SEND;
      end
      R_SEND: begin
        rd_addr = rd_ptr_q[AW-1:0] + AW'(1);
        if (m_valid_q && m_axis_tready_i) begin
          rd_ptr_d    = rd_ptr_q + PW'(1);
          remaining_d = remaining_q - PW'(1);
          rd_addr     = rd_ptr_q[AW-1:0] + AW'(2);
          if (m_last_q) begin
            complete  = 1'b1;
            m_valid_d = 1'b0;
            m_last_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            m_data_d = rdata_q;
            m_last_d = remaining_q == PW'(2);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    q_wr_d    = q_wr_q + (push ? (QA + 1)'(1) : '0);
    pending_d = pending_q;
    case ({push, complete})
      2'b10:   pending_d = pending_q + (QA + 1)'(1);
      2'b01:   pending_d = pending_q - (QA + 1)'(1);
      default: pending_d = pending_q;
    endcase
    drop_d = (drop_inc && drop_q != '1) ? drop_q + CNT_W'(1) : drop_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      w_state_q    <= W_IDLE;
      r_state_q    <= R_IDLE;
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      remaining_q  <= '0;
      q_wr_q       <= '0;
      q_rd_q       <= '0;
      pending_q    <= '0;
      drop_q       <= '0;
      m_valid_q    <= 1'b0;
      m_last_q     <= 1'b0;
      m_data_q     <= '0;
    end else begin
      w_state_q    <= w_state_d;
      r_state_q    <= r_state_d;
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      len_q        <= len_d;
      remaining_q  <= remaining_d;
      q_wr_q       <= q_wr_d;
      q_rd_q       <= q_rd_d;
      pending_q    <= pending_d;
      drop_q       <= drop_d;
      m_valid_q    <= m_valid_d;
      m_last_q     <= m_last_d;
      m_data_q     <= m_data_d;
    end
  end

  // Storage arrays carry no reset so they map onto block / distributed RAM.
  always_ff @(posedge clk_i) begin
    if (we) mem[wr_ptr_q[AW-1:0]] <= s_axis_tdata_i;
    rdata_q <= mem[rd_addr];
  end

  always_ff @(posedge clk_i) begin
    if (push) lenq[q_wr_q[QA-1:0]] <= len_d;
  end

  assign m_axis_tvalid_o  = m_valid_q;
  assign m_axis_tdata_o   = m_data_q;
  assign m_axis_tlast_o   = m_last_q;
  assign frames_pending_o = pending_q;
  assign drop_count_o     = drop_q;

endmodule

// File: tb/tb_rx_frame_buffer_ctrl.sv
// Directed bench for rx_frame_buffer_ctrl with a 64-byte buffer and an 8-entry frame queue.
module tb_rx_frame_buffer_ctrl;

  logic        clk;
  logic        rst_n;
  logic        s_tvalid;
  logic [7:0]  s_tdata;
  logic        s_tlast;
  logic        m_tvalid;
  logic [7:0]  m_tdata;
  logic        m_tlast;
  logic        m_tready;
  logic [3:0]  pending;
  logic [15:0] drops;

  int n_pass = 0;
  int n_total = 0;
  int total_bytes = 0;

  rx_frame_buffer_ctrl #(
    .DEPTH_BYTES(64),
    .MAX_FRAMES (8),
    .CNT_W      (16)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .s_axis_tvalid_i  (s_tvalid),
    .s_axis_tdata_i   (s_tdata),
    .s_axis_tlast_i   (s_tlast),
    .m_axis_tvalid_o  (m_tvalid),
    .m_axis_tdata_o   (m_tdata),
    .m_axis_tlast_o   (m_tlast),
    .m_axis_tready_i  (m_tready),
    .frames_pending_o (pending),
    .drop_count_o     (drops)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Frame byte i carries (base + i); sep_last sends tlast on its own cycle with tvalid low.
  task automatic send_frame(input int len, input int base, input bit sep_last);
    for (int i = 0; i < len; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(base + i);
      s_tlast  = (i == len - 1) && !sep_last;
      tick();
    end
    if (sep_last) begin
      s_tvalid = 1'b0;
      s_tlast  = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic recv_frame(input int len, input int base, input bit rnd);
    int         idx = 0;
    int         cyc = 0;
    bit         held = 0;
    logic [7:0] hd = '0;
    logic       hl = 1'b0;
    logic [7:0] exp_b;
    while (idx < len && cyc < 2000) begin
      if (held) begin
        check("stall_valid", m_tvalid, 1);
        check("stall_data", m_tdata, hd);
        check("stall_last", m_tlast, hl);
      end
      if (!rnd && idx > 0) check("no_bubble", m_tvalid, 1);
      m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      held = 0;
      if (m_tvalid && m_tready) begin
        exp_b = 8'(base + idx);
        check("beat_data", m_tdata, exp_b);
        check("beat_last", m_tlast, (idx == len - 1) ? 1 : 0);
        idx++;
        total_bytes++;
      end else if (m_tvalid) begin
        held = 1;
        hd   = m_tdata;
        hl   = m_tlast;
      end
      tick();
      cyc++;
    end
    check("recv_timeout", idx, len);
  endtask

  initial begin
    rst_n    = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    m_tready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_tvalid, 0);
    check("rst_tdata", m_tdata, 0);
    check("rst_tlast", m_tlast, 0);
    check("rst_pending", pending, 0);
    check("rst_drops", drops, 0);
    rst_n = 1'b1;
    tick();

    // 64-byte frame fills the buffer exactly; tvalid two cycles after tlast.
    m_tready = 1'b1;
    send_frame(64, 8'h00, 0);
    check("t1_lat0", m_tvalid, 0);
    check("t1_pending1", pending, 1);
    tick();
    check("t1_lat1", m_tvalid, 0);
    tick();
    check("t1_lat2", m_tvalid, 1);
    check("t1_first", m_tdata, 8'h00);
    recv_frame(64, 8'h00, 0);
    check("t1_pending0", pending, 0);
    check("t1_idle", m_tvalid, 0);

    // Back-to-back 10/1/20-byte frames held back, then drained with random tready.
    m_tready = 1'b0;
    send_frame(10, 8'h10, 0);
    send_frame(1, 8'hA0, 0);
    send_frame(20, 8'h40, 0);
    check("t2_pending3", pending, 3);
    recv_frame(10, 8'h10, 1);
    recv_frame(1, 8'hA0, 1);
    recv_frame(20, 8'h40, 1);
    m_tready = 1'b0;
    tick();
    check("t2_pending0", pending, 0);

    // 70-byte frame overflows the 64-byte buffer; the next frame is intact.
    send_frame(70, 8'h00, 0);
    tick();
    check("t3_drops", drops, 1);
    check("t3_pending", pending, 0);
    check("t3_tvalid", m_tvalid, 0);
    send_frame(8, 8'h80, 0);
    recv_frame(8, 8'h80, 1);
    m_tready = 1'b0;

    // Nine 4-byte frames: the ninth exceeds the 8-frame limit (drop counter is cumulative).
    for (int f = 0; f < 9; f++) send_frame(4, f * 16, 0);
    check("t4_pending8", pending, 8);
    check("t4_drops", drops, 2);
    total_bytes = 0;
    for (int f = 0; f < 8; f++) recv_frame(4, f * 16, 0);
    for (int c = 0; c < 8; c++) begin
      if (m_tvalid && m_tready) total_bytes++;
      tick();
    end
    check("t4_bytes32", total_bytes, 32);
    check("t4_pending0", pending, 0);
    m_tready = 1'b0;

    // Separate tlast pulse, then a stray tlast while idle.
    send_frame(5, 8'h30, 1);
    s_tlast = 1'b1;
    tick();
    s_tlast = 1'b0;
    send_frame(3, 8'h60, 0);
    check("t5_pending2", pending, 2);
    check("t5_drops", drops, 2);
    recv_frame(5, 8'h30, 1);
    recv_frame(3, 8'h60, 1);
    m_tready = 1'b0;
    tick();
    check("t5_pending0", pending, 0);

    // Asynchronous reset mid-frame, then mid-readout.
    for (int i = 0; i < 3; i++) begin
      s_tvalid = 1'b1;
      s_tdata  = 8'(8'h90 + i);
      tick();
    end
    s_tvalid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("t6a_drops", drops, 0);
    check("t6a_pending", pending, 0);
    check("t6a_tvalid", m_tvalid, 0);
    #2 rst_n = 1'b1;
    tick();
    send_frame(4, 8'hC0, 0);
    for (int c = 0; c < 10 && !m_tvalid; c++) tick();
    check("t6b_tvalid", m_tvalid, 1);
    check("t6b_tdata", m_tdata, 8'hC0);
    check("t6b_pending", pending, 1);
    #3 rst_n = 1'b0;
    #1;
    check("t6b_rst_tvalid", m_tvalid, 0);
    check("t6b_rst_tdata", m_tdata, 0);
    check("t6b_rst_tlast", m_tlast, 0);
    check("t6b_rst_pending", pending, 0);
    check("t6b_rst_drops", drops, 0);
    #2 rst_n = 1'b1;
    tick();
    send_frame(6, 8'hE0, 0);
    recv_frame(6, 8'hE0, 1);
    m_tready = 1'b0;
    tick();
    check("t6_pending0", pending, 0);
    check("t6_drops0", drops, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
